servo_pwm_gen: RTL and testbench
================================

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 SHALL have parameter N, default 8: position word width.
REQ-002 SHALL have parameter PERIOD_CYC, default 2000000: frame length in clk cycles (20 ms at 100 MHz).
REQ-003 SHALL have parameter MIN_CYC, default 100000: pulse width for position 0 (1 ms).
REQ-004 SHALL have parameter STEP_CYC, default 392: pulse width added per position LSB.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-007 SHALL have port run  input  1  1 = generate frames, 0 = stop at end of current frame.
REQ-008 SHALL have port pos_in  input  N  new servo position, fed from the upstream pipeline register output.
REQ-009 SHALL have port pos_valid  input  1  one-cycle strobe qualifying pos_in.
REQ-010 SHALL have port pwm_out  output  1  registered servo PWM drive.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse on first cycle of every frame.
REQ-012 SHALL have port pos_active  output  N  position in effect for the current frame.
REQ-013 SHALL have port busy  output  1  1 while in state ACTIVE.

Function
REQ-014 SHALL implement states IDLE and ACTIVE; frame counter cnt counts 0..PERIOD_CYC-1 in ACTIVE, wraps to 0.
REQ-015 IDLE -> ACTIVE SHALL occur on the edge where run=1 is sampled; that edge starts a frame (cnt=0).
REQ-016 ACTIVE -> IDLE SHALL occur only on the edge ending cnt=PERIOD_CYC-1 with run=0 sampled; a frame is never truncated by run.
REQ-017 Pulse width SHALL be W = MIN_CYC + pos_active*STEP_CYC, computed at full precision (no truncation, width >= bits of PERIOD_CYC).
REQ-018 pwm_out SHALL be 1 for exactly W consecutive cycles starting on the frame_start cycle, then 0 until frame end; 0 in IDLE.
REQ-019 frame_start SHALL be 1 exactly on cycles where state=ACTIVE and cnt=0; successive pulses PERIOD_CYC cycles apart.
REQ-020 pos_valid=1 sampled on an edge SHALL store pos_in into a pending register and set a pending flag; later strobes before the next frame start overwrite it (last wins).
REQ-021 On each frame-start edge, if pending flag set from an earlier edge, pos_active SHALL load pending value and the flag clears; else pos_active holds.
REQ-022 A pos_valid sampled on the frame-start edge itself SHALL be pending for the following frame, not the one starting.
REQ-023 pos_active SHALL never change mid-frame; glitch-free pulse guaranteed.
REQ-024 pos_valid SHALL be accepted in IDLE too; applied on the frame-start edge leaving IDLE.
REQ-025 Parameters SHALL satisfy MIN_CYC + (2^N-1)*STEP_CYC < PERIOD_CYC; pwm_out therefore always falls inside every frame.

Reset
REQ-026 With reset=0 sampled, next cycle SHALL give: state IDLE, cnt=0, pwm_out=0, frame_start=0, busy=0, pos_active=0, pending flag=0, regardless of run/pos_valid.
REQ-027 reset=0 mid-pulse SHALL drive pwm_out to 0 on the next cycle; on release, operation restarts with pos_active=0 (W=MIN_CYC).

Verification (bench params N=4, PERIOD_CYC=40, MIN_CYC=5, STEP_CYC=2)
REQ-028 Reset then run=1, no pos_valid -> frame_start every 40 cycles, pwm_out high 5 cycles per frame, pos_active=0.
REQ-029 pos_valid with pos_in=15 mid-frame -> current frame keeps old width; next frame pwm high 35 cycles, pos_active=15.
REQ-030 Strobes pos_in=3 then pos_in=9 within one frame -> next frame width 23 (9 wins); strobe on frame_start cycle with 6 -> applies frame after (width 17).
REQ-031 run dropped at cnt=10 -> frame completes through cnt=39, then IDLE, busy=0, no further frame_start, pwm_out=0.
REQ-032 reset=0 asserted at cnt=3 of a pos 15 frame -> pwm_out=0 next cycle, all outputs at reset values; after release with run=1, width 5.
REQ-033 Every frame -> checker asserts pwm high count equals 5+2*pos_active and exactly one rising edge per frame.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: frame-based servo PWM generator with double-buffered position.
// Rev 1.0 -- initial release.
`default_nettype none

module servo_pwm_gen #(
  parameter int N          = 8,
  parameter int PERIOD_CYC = 2000000,
  parameter int MIN_CYC    = 100000,
  parameter int STEP_CYC   = 392
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [N-1:0] pos_in,
  input  logic         pos_valid,
  output logic         pwm_out,
  output logic         frame_start,
  output logic [N-1:0] pos_active,
  output logic         busy
);

  localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int WW = 64;
  localparam logic [CW-1:0] C_LAST = CW'(PERIOD_CYC - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_start;
  logic            r_pend;
  logic [N-1:0]    r_pend_val;
  logic [N-1:0]    w_pos_nxt;
  logic [WW-1:0]   w_width;
  logic            w_pwm_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = '0;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt = '0;
          if (run) w_start = 1'b1;
          else     w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Position only changes on a frame-start edge, so the pulse can never glitch mid-frame.
    w_pos_nxt = (w_start && r_pend) ? r_pend_val : pos_active;
    w_width   = WW'(MIN_CYC) + WW'(w_pos_nxt) * WW'(STEP_CYC);
    w_pwm_nxt = (w_state_nxt == ACTIVE) && (WW'(w_cnt_nxt) < w_width);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      pwm_out    <= 1'b0;
      pos_active <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      pwm_out    <= w_pwm_nxt;
      pos_active <= w_pos_nxt;
      // A strobe on the frame-start edge itself stays pending for the next frame.
      if (pos_valid) begin
        r_pend     <= 1'b1;
        r_pend_val <= pos_in;
      end else if (w_start) begin
        r_pend     <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == ACTIVE);
  assign frame_start = (r_state == ACTIVE) && (r_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed and randomized checks against a frame-level reference model.
`default_nettype none

module tb_servo_pwm_gen;
  localparam int N      = 4;
  localparam int PERIOD = 40;
  localparam int MINC   = 5;
  localparam int STEP   = 2;

  logic         clk = 1'b0;
  logic         reset, run, pos_valid;
  logic [N-1:0] pos_in;
  logic         pwm_out, frame_start, busy;
  logic [N-1:0] pos_active;

  always #5 clk = ~clk;

  servo_pwm_gen #(.N(N), .PERIOD_CYC(PERIOD), .MIN_CYC(MINC), .STEP_CYC(STEP)) dut (
    .clk(clk), .reset(reset), .run(run), .pos_in(pos_in), .pos_valid(pos_valid),
    .pwm_out(pwm_out), .frame_start(frame_start), .pos_active(pos_active), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: frame position, position in effect, and last pending strobe.
  bit   m_busy = 0;
  int   m_cnt = 0, m_pos = 0, m_pend_val = 0;
  bit   m_pend = 0;
  logic [6:0] exp_v = '0;
  logic [6:0] obs;
  assign obs = {pwm_out, frame_start, busy, pos_active};

  task automatic tick(input bit r, input bit ru, input bit v, input int p);
    bit start;
    reset = r; run = ru; pos_valid = v; pos_in = N'(p);
    @(posedge clk);
    start = 0;
    if (!r) begin
      m_busy = 0; m_cnt = 0; m_pos = 0; m_pend = 0; m_pend_val = 0;
    end else begin
      if (!m_busy) begin
        if (ru) begin m_busy = 1; m_cnt = 0; start = 1; end
      end else if (m_cnt == PERIOD - 1) begin
        m_cnt = 0;
        if (ru) start = 1; else m_busy = 0;
      end else begin
        m_cnt++;
      end
      if (start && m_pend) begin m_pos = m_pend_val; m_pend = 0; end
      if (v) begin m_pend = 1; m_pend_val = p; end
    end
    exp_v = {m_busy && (m_cnt < MINC + STEP * m_pos), m_busy && (m_cnt == 0), m_busy, N'(m_pos)};
    #1;
  endtask

  task automatic to_cnt(input int target);
    int n = 0;
    while (!(m_busy && m_cnt == target) && n < 100) begin tick(1, 1, 0, 0); n++; end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL to_cnt target=%0d not reached, model cnt=%0d", target, m_cnt);
    end
  endtask

  // Call with the model idle or at the last frame cycle; the first tick is the frame start.
  task automatic measure_frame(output int hi);
    hi = 0;
    repeat (PERIOD) begin tick(1, 1, 0, 0); hi += int'(pwm_out); end
  endtask

  // Independent per-frame checker: exactly one pulse of the expected width.
  bit mon_on = 0;
  int mon_hi = 0, mon_rises = 0, mon_pos = 0;
  bit mon_prev = 0;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mon_on = 0;
    end else begin
      if (frame_start === 1'b1 || (mon_on && busy !== 1'b1)) begin
        if (mon_on) begin
          checks++;
          if (mon_hi != MINC + STEP * mon_pos || mon_rises != 1) begin
            errors++;
            $display("FAIL frame_pulse t=%0t high=%0d rises=%0d required high=%0d rises=1",
                     $time, mon_hi, mon_rises, MINC + STEP * mon_pos);
          end
        end
        mon_on = (frame_start === 1'b1);
        mon_hi = 0; mon_rises = 0; mon_pos = int'(pos_active); mon_prev = 0;
      end
      if (mon_on) begin
        if (pwm_out === 1'b1 && !mon_prev) mon_rises++;
        if (pwm_out === 1'b1) mon_hi++;
        mon_prev = (pwm_out === 1'b1);
      end
    end
  end

  task automatic test_reset();
    repeat (3) begin
      tick(0, 1, 1, 7);
      checks++;
      if (obs !== 7'b0) begin
        errors++; $display("FAIL reset_state got=%b required=%b", obs, 7'b0);
      end
    end
  endtask

  task automatic test_idle_frames();
    int fs = 0, hi = 0;
    repeat (2 * PERIOD) begin
      tick(1, 1, 0, 0);
      fs += int'(frame_start); hi += int'(pwm_out);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL idle_frames t=%0t got=%b required=%b", $time, obs, exp_v);
      end
    end
    checks++;
    if (fs != 2 || hi != 2 * MINC) begin
      errors++; $display("FAIL idle_frames_count starts=%0d high=%0d required 2 and %0d", fs, hi, 2 * MINC);
    end
  endtask

  task automatic test_pos_update();
    int hi;
    to_cnt(20);
    tick(1, 1, 1, 15);
    checks++;
    if (pos_active !== 4'd0 || obs !== exp_v) begin
      errors++; $display("FAIL pos_midframe got=%b required=%b", obs, exp_v);
    end
    to_cnt(PERIOD - 1);
    measure_frame(hi);
    checks++;
    if (hi != 35 || pos_active !== 4'd15) begin
      errors++; $display("FAIL pos_update high=%0d pos=%0d required 35 and 15", hi, pos_active);
    end
  endtask

  task automatic test_last_wins();
    int hi;
    to_cnt(5);
    tick(1, 1, 1, 3);
    to_cnt(12);
    tick(1, 1, 1, 9);
    to_cnt(PERIOD - 1);
    tick(1, 1, 1, 6);
    checks++;
    if (frame_start !== 1'b1 || pos_active !== 4'd9) begin
      errors++; $display("FAIL last_wins_start fs=%b pos=%0d required 1 and 9", frame_start, pos_active);
    end
    hi = int'(pwm_out);
    repeat (PERIOD - 1) begin tick(1, 1, 0, 0); hi += int'(pwm_out); end
    checks++;
    if (hi != 23) begin
      errors++; $display("FAIL last_wins_width high=%0d required 23", hi);
    end
    measure_frame(hi);
    checks++;
    if (hi != 17 || pos_active !== 4'd6) begin
      errors++; $display("FAIL strobe_on_start high=%0d pos=%0d required 17 and 6", hi, pos_active);
    end
  endtask

  task automatic test_run_stop();
    int bad = 0;
    to_cnt(9);
    repeat (30) begin
      tick(1, 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL run_stop_tail t=%0t got=%b required=%b", $time, obs, exp_v);
      end
    end
    checks++;
    if (busy !== 1'b1 || frame_start !== 1'b0) begin
      errors++; $display("FAIL run_stop_last busy=%b fs=%b required 1 and 0", busy, frame_start);
    end
    repeat (50) begin
      tick(1, 0, 0, 0);
      if (busy !== 1'b0 || frame_start !== 1'b0 || pwm_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL run_stop_idle active_cycles=%0d required 0", bad);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int hi;
    tick(1, 0, 1, 15);
    tick(1, 1, 0, 0);
    to_cnt(3);
    checks++;
    if (pwm_out !== 1'b1 || pos_active !== 4'd15) begin
      errors++; $display("FAIL pre_reset pwm=%b pos=%0d required 1 and 15", pwm_out, pos_active);
    end
    tick(0, 1, 1, 12);
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL reset_mid_pulse got=%b required=%b", obs, 7'b0);
    end
    measure_frame(hi);
    checks++;
    if (hi != MINC || pos_active !== 4'd0) begin
      errors++; $display("FAIL after_reset high=%0d pos=%0d required %0d and 0", hi, pos_active, MINC);
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      tick($urandom_range(0, 299) != 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 29) == 0, int'($urandom_range(0, 15)));
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random t=%0t got=%b required=%b", $time, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; pos_valid = 1'b0; pos_in = '0;
    test_reset();
    test_idle_frames();
    test_pos_update();
    test_last_wins();
    test_run_stop();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
